// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer:
//   state_e        - sequencer state encoding, also driven onto oSTATE
//   cnt_width_for  - minimum counter width able to hold the largest delay
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STAGE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Bits needed to represent the largest of the three delay values.
  function automatic int cnt_width_for(input int init_delay,
                                       input int stage_gap,
                                       input int wdt_timeout);
    int m;
    m = init_delay;
    if (stage_gap > m)   m = stage_gap;
    if (wdt_timeout > m) m = wdt_timeout;
    return (m <= 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Request/status bundle of the reset sequencer.
//   iSOFT_RST  - synchronous soft-reset request, active-high
//   iWDT_KICK  - watchdog kick pulse, active-high
//   oRESET     - NUM_OUT active-low resets, 1 = released
//   oREADY     - all outputs released
//   oSTATE     - sequencer state (HOLD=0, WAIT=1, STAGE=2, RUN=3)
//   oWDT_FIRED - sticky watchdog-fired flag
// master: the system side issuing requests; slave: the sequencer.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
  parameter int NUM_OUT = 3
);
  logic               iSOFT_RST;
  logic               iWDT_KICK;
  logic [NUM_OUT-1:0] oRESET;
  logic               oREADY;
  logic [1:0]         oSTATE;
  logic               oWDT_FIRED;

  modport master (
    output iSOFT_RST, iWDT_KICK,
    input  oRESET, oREADY, oSTATE, oWDT_FIRED
  );

  modport slave (
    input  iSOFT_RST, iWDT_KICK,
    output oRESET, oREADY, oSTATE, oWDT_FIRED
  );
endinterface

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
// Asynchronous-assert / synchronous-deassert reset synchroniser.
//   clk        - destination clock
//   rst_n      - asynchronous active-low reset in
//   sync_rst_n - reset released STAGES edges after rst_n rises, cleared
//                immediately when rst_n falls
// -----------------------------------------------------------------------------
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_rst_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Synchronises the board reset, waits INIT_DELAY cycles, then releases the
// NUM_OUT active-low reset outputs in order, STAGE_GAP cycles apart. A soft
// reset (or a watchdog fire) restarts the sequence from HOLD.
//   iCLK - system clock
//   iRST - asynchronous active-low reset (pushbutton)
//   bus  - reset_sequencer_if.slave: iSOFT_RST, iWDT_KICK, oRESET, oREADY,
//          oSTATE, oWDT_FIRED
// Optional feature macro: RESET_SEQ_WATCHDOG_EN builds the RUN-state watchdog;
// without it iWDT_KICK is ignored and oWDT_FIRED is tied low.
// -----------------------------------------------------------------------------
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int CNT_W       = 28,
  parameter int INIT_DELAY  = 28'h4FFFFFF,
  parameter int STAGE_GAP   = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_TIMEOUT = 28'h2FAF080
) (
  input  logic            iCLK,
  input  logic            iRST,
  reset_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_OUT + 1);

  if (NUM_OUT < 1)     begin : g_chk_num   $error("NUM_OUT must be >= 1");    end
  if (STAGE_GAP < 1)   begin : g_chk_gap   $error("STAGE_GAP must be >= 1");  end
  if (SYNC_STAGES < 2) begin : g_chk_sync  $error("SYNC_STAGES must be >= 2"); end
  if (CNT_W < cnt_width_for(INIT_DELAY, STAGE_GAP, WDT_TIMEOUT)) begin : g_chk_cnt
    $error("CNT_W too narrow for the configured delays");
  end

  logic               rst_s;
  logic               wdt_fire;
  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ready_q,   ready_d;

  rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (iCLK),
    .rst_n      (iRST),
    .sync_rst_n (rst_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        if (rst_s && !bus.iSOFT_RST) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(INIT_DELAY)) begin
          rst_out_d[0] = 1'b1;
          cnt_d        = '0;
          idx_d        = IDX_W'(1);
          if (NUM_OUT == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_STAGE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STAGE: begin
        // The counter restarts at 0 on each release, so the edge on which it
        // would reach STAGE_GAP is exactly STAGE_GAP cycles after the last one.
        if (cnt_q + CNT_W'(1) == CNT_W'(STAGE_GAP)) begin
          rst_out_d = rst_out_q | (NUM_OUT'(1) << idx_q);
          cnt_d     = '0;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ; // ST_RUN: outputs hold until a reset event
    endcase

    // Reset event overrides any progress made this cycle.
    if (state_q != ST_HOLD && (bus.iSOFT_RST || wdt_fire)) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '0;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             fired_q, fired_d;

  // Fires on the edge where the count would reach WDT_TIMEOUT; any exit from
  // RUN (soft reset or fire) clears the count.
  always_comb begin
    wdt_d    = '0;
    wdt_fire = 1'b0;
    fired_d  = fired_q;
    if (state_q == ST_RUN && !bus.iWDT_KICK) begin
      if (wdt_q == CNT_W'(WDT_TIMEOUT - 1)) begin
        wdt_fire = 1'b1;
        fired_d  = 1'b1;
      end else if (!bus.iSOFT_RST) begin
        wdt_d = wdt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fired_q <= fired_d;
    end
  end

  assign bus.oWDT_FIRED = fired_q;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = bus.iWDT_KICK;
  assign wdt_fire        = 1'b0;
  assign bus.oWDT_FIRED  = 1'b0;
`endif

  assign bus.oRESET = rst_out_q;
  assign bus.oREADY = ready_q;
  assign bus.oSTATE = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with NUM_OUT=3, INIT_DELAY=10,
// STAGE_GAP=4, SYNC_STAGES=2, WDT_TIMEOUT=8. Expected output snapshots are
// queued with the edge index at which they apply (relative to an anchor taken
// just before edge E0 of each scenario) and compared on the falling edge.
// RESET_SEQ_WATCHDOG_EN selects the watchdog scenario variant.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  localparam int NUM_OUT     = 3;
  localparam int CNT_W       = 28;
  localparam int INIT_DELAY  = 10;
  localparam int STAGE_GAP   = 4;
  localparam int SYNC_STAGES = 2;
  localparam int WDT_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_OUT(NUM_OUT)) bus ();

  reset_sequencer #(
    .NUM_OUT     (NUM_OUT),
    .CNT_W       (CNT_W),
    .INIT_DELAY  (INIT_DELAY),
    .STAGE_GAP   (STAGE_GAP),
    .SYNC_STAGES (SYNC_STAGES),
    .WDT_TIMEOUT (WDT_TIMEOUT)
  ) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string          tag;
    int unsigned    at;
    logic [2:0]     rst;
    logic [1:0]     st;
    logic           rdy;
    logic           wdt;
  } exp_t;

  exp_t        sb[$];
  int unsigned anchor = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Anchor at a falling edge: the next rising edge is E0.
  task automatic mark();
    anchor = cyc;
  endtask

  task automatic expect_after(input string tag, input int unsigned k,
                              input logic [2:0] r, input logic [1:0] s,
                              input logic rdy, input logic w);
    sb.push_back('{tag: tag, at: anchor + k + 1, rst: r, st: s, rdy: rdy, wdt: w});
  endtask

  task automatic expect_now(input string tag, input logic [2:0] r, input logic [1:0] s,
                            input logic rdy, input logic w);
    sb.push_back('{tag: tag, at: cyc, rst: r, st: s, rdy: rdy, wdt: w});
  endtask

  task automatic drain();
    exp_t e;
    int   guard;
    while (sb.size() != 0) begin
      e     = sb.pop_front();
      guard = 0;
      while (cyc < e.at && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      check({e.tag, ".rst"},   32'(bus.oRESET),     32'(e.rst));
      check({e.tag, ".state"}, 32'(bus.oSTATE),     32'(e.st));
      check({e.tag, ".ready"}, 32'(bus.oREADY),     32'(e.rdy));
      check({e.tag, ".wdt"},   32'(bus.oWDT_FIRED), 32'(e.wdt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.iSOFT_RST = 1'b0;
    bus.iWDT_KICK = 1'b0;
    repeat (3) @(negedge clk);
    expect_now("reset", 3'b000, ST_HOLD, 1'b0, 1'b0);
    drain();

    // Power-on, aborted asynchronously between E14 and E15.
    rst_n = 1'b1;
    mark();
    expect_after("po_e1",  1,  3'b000, ST_HOLD,  1'b0, 1'b0);
    expect_after("po_e2",  2,  3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("po_e11", 11, 3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("po_e12", 12, 3'b001, ST_STAGE, 1'b0, 1'b0);
    expect_after("po_e14", 14, 3'b001, ST_STAGE, 1'b0, 1'b0);
    drain();
    rst_n = 1'b0;
    #1;
    expect_now("abort", 3'b000, ST_HOLD, 1'b0, 1'b0);
    drain();

    // Full power-on sequence.
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    expect_after("pw_e1",  1,  3'b000, ST_HOLD,  1'b0, 1'b0);
    expect_after("pw_e2",  2,  3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("pw_e11", 11, 3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("pw_e12", 12, 3'b001, ST_STAGE, 1'b0, 1'b0);
    expect_after("pw_e15", 15, 3'b001, ST_STAGE, 1'b0, 1'b0);
    expect_after("pw_e16", 16, 3'b011, ST_STAGE, 1'b0, 1'b0);
    expect_after("pw_e19", 19, 3'b011, ST_STAGE, 1'b0, 1'b0);
    expect_after("pw_e20", 20, 3'b111, ST_RUN,   1'b1, 1'b0);
    drain();

    // One-cycle soft reset in RUN, sampled at E0: WAIT from E1, releases E11/E15/E19.
    bus.iSOFT_RST = 1'b1;
    mark();
    @(negedge clk);
    bus.iSOFT_RST = 1'b0;
    expect_after("sr_e0",  0,  3'b000, ST_HOLD,  1'b0, 1'b0);
    expect_after("sr_e1",  1,  3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("sr_e10", 10, 3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("sr_e11", 11, 3'b001, ST_STAGE, 1'b0, 1'b0);
    expect_after("sr_e15", 15, 3'b011, ST_STAGE, 1'b0, 1'b0);
    expect_after("sr_e18", 18, 3'b011, ST_STAGE, 1'b0, 1'b0);
    expect_after("sr_e19", 19, 3'b111, ST_RUN,   1'b1, 1'b0);
    drain();

    // Restart, then hold soft reset for 5 cycles while in STAGE.
    bus.iSOFT_RST = 1'b1;
    mark();
    @(negedge clk);
    bus.iSOFT_RST = 1'b0;
    expect_after("hs_pre", 13, 3'b001, ST_STAGE, 1'b0, 1'b0);
    drain();
    bus.iSOFT_RST = 1'b1;
    mark();
    for (int k = 0; k < 5; k++) begin
      expect_after($sformatf("hs_hold%0d", k), k, 3'b000, ST_HOLD, 1'b0, 1'b0);
    end
    drain();
    bus.iSOFT_RST = 1'b0;
    expect_after("hs_e5",  5,  3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("hs_e14", 14, 3'b000, ST_WAIT,  1'b0, 1'b0);
    expect_after("hs_e15", 15, 3'b001, ST_STAGE, 1'b0, 1'b0);
    expect_after("hs_e19", 19, 3'b011, ST_STAGE, 1'b0, 1'b0);
    expect_after("hs_e23", 23, 3'b111, ST_RUN,   1'b1, 1'b0);
    drain();

`ifdef RESET_SEQ_WATCHDOG_EN
    // Regular kicks every 6 cycles keep the watchdog quiet.
    for (int i = 0; i < 9; i++) begin
      bus.iWDT_KICK = 1'b1;
      @(negedge clk);
      bus.iWDT_KICK = 1'b0;
      repeat (5) @(negedge clk);
      expect_now($sformatf("wd_kick%0d", i), 3'b111, ST_RUN, 1'b1, 1'b0);
      drain();
    end
    // Last kick sampled at E0; fire 8 cycles later, then a sticky flag.
    bus.iWDT_KICK = 1'b1;
    mark();
    @(negedge clk);
    bus.iWDT_KICK = 1'b0;
    expect_after("wd_e7",   7,  3'b111, ST_RUN,   1'b1, 1'b0);
    expect_after("wd_fire", 8,  3'b000, ST_HOLD,  1'b0, 1'b1);
    expect_after("wd_e9",   9,  3'b000, ST_WAIT,  1'b0, 1'b1);
    expect_after("wd_e19",  19, 3'b001, ST_STAGE, 1'b0, 1'b1);
    expect_after("wd_e27",  27, 3'b111, ST_RUN,   1'b1, 1'b1);
    drain();
    rst_n = 1'b0;
    #1;
    expect_now("wd_clear", 3'b000, ST_HOLD, 1'b0, 1'b0);
    drain();
`else
    // Without the watchdog, RUN persists with no kicks.
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      expect_now($sformatf("nowd_run%0d", i), 3'b111, ST_RUN, 1'b1, 1'b0);
      drain();
    end
    rst_n = 1'b0;
    #1;
    expect_now("nowd_reset", 3'b000, ST_HOLD, 1'b0, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
